// File: rtl/dac_spi_scheduler.sv
// Owns the DAC SPI transmitter: sends the init word sequence after reset, then
// arbitrates between stereo sample pairs and raw control words.
module dac_spi_scheduler #(
  parameter logic [7:0]  CHANNEL_A      = 8'h31,
  parameter logic [7:0]  CHANNEL_B      = 8'h32,
  parameter int unsigned INIT_COUNT     = 2,
  parameter logic [23:0] INIT_WORD_0    = 24'h3C0000,
  parameter logic [23:0] INIT_WORD_1    = 24'h300000,
  parameter logic [23:0] INIT_WORD_2    = 24'h000000,
  parameter logic [23:0] INIT_WORD_3    = 24'h000000,
  parameter int unsigned CTRL_STARVE    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Sample_Req,
  input  logic [15:0] i_Sample_A,
  input  logic [15:0] i_Sample_B,
  output logic        o_Sample_Ack,
  input  logic        i_Ctrl_Req,
  input  logic [23:0] i_Ctrl_Data,
  output logic        o_Ctrl_Ack,
  output logic [23:0] o_DAC_Data,
  output logic        o_DAC_Send,
  input  logic        i_DAC_Ready,
  output logic        o_Init_Done,
  output logic        o_Busy,
  output logic        o_Error
);

  localparam int unsigned SW = $clog2(CTRL_STARVE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_START,
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          pend_b_q, pend_b_d;
  logic [15:0]   samp_b_q, samp_b_d;
  logic [23:0]   data_d;
  logic          send_d, sack_d, cack_d, init_done_d, busy_d, err_d;

  logic grant_ctrl, grant_samp, last_init, timeout_hit;

  function automatic logic [23:0] init_word(input logic [1:0] i);
    case (i)
      2'd0:    return INIT_WORD_0;
      2'd1:    return INIT_WORD_1;
      2'd2:    return INIT_WORD_2;
      default: return INIT_WORD_3;
    endcase
  endfunction

  // Control wins only when samples are idle or control has waited CTRL_STARVE pairs.
  assign grant_ctrl  = i_Ctrl_Req && (!i_Sample_Req || starve_q == SW'(CTRL_STARVE));
  assign grant_samp  = i_Sample_Req && !grant_ctrl;
  assign last_init   = (idx_q == 2'(INIT_COUNT - 1));
  assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= S_START;
      idx_q        <= '0;
      starve_q     <= '0;
      tcnt_q       <= '0;
      pend_b_q     <= 1'b0;
      samp_b_q     <= '0;
      o_DAC_Data   <= '0;
      o_DAC_Send   <= 1'b0;
      o_Sample_Ack <= 1'b0;
      o_Ctrl_Ack   <= 1'b0;
      o_Init_Done  <= 1'b0;
      o_Busy       <= 1'b0;
      o_Error      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      starve_q     <= starve_d;
      tcnt_q       <= tcnt_d;
      pend_b_q     <= pend_b_d;
      samp_b_q     <= samp_b_d;
      o_DAC_Data   <= data_d;
      o_DAC_Send   <= send_d;
      o_Sample_Ack <= sack_d;
      o_Ctrl_Ack   <= cack_d;
      o_Init_Done  <= init_done_d;
      o_Busy       <= busy_d;
      o_Error      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:     if (i_DAC_Ready) state_d = S_SEND;
      S_IDLE:      if (grant_ctrl || grant_samp) state_d = S_SEND;
      S_SEND:      state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!i_DAC_Ready)     state_d = S_WAIT_DONE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (i_DAC_Ready) begin
          if (pend_b_q || (!o_Init_Done && !last_init)) state_d = S_SEND;
          else                                           state_d = S_IDLE;
        end
      end
      default:     state_d = S_START;
    endcase
  end

  // Outputs are registered; this block computes their next values.
  always_comb begin
    idx_d       = idx_q;
    starve_d    = starve_q;
    tcnt_d      = tcnt_q;
    pend_b_d    = pend_b_q;
    samp_b_d    = samp_b_q;
    data_d      = o_DAC_Data;
    send_d      = o_DAC_Send;
    sack_d      = 1'b0;
    cack_d      = 1'b0;
    init_done_d = o_Init_Done;
    err_d       = o_Error;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_START: begin
        if (i_DAC_Ready) data_d = init_word(idx_q);
      end
      S_IDLE: begin
        if (grant_ctrl) begin
          data_d   = i_Ctrl_Data;
          cack_d   = 1'b1;
          starve_d = '0;
        end else if (grant_samp) begin
          data_d   = {CHANNEL_A, i_Sample_A};
          samp_b_d = i_Sample_B;
          pend_b_d = 1'b1;
          sack_d   = 1'b1;
          starve_d = i_Ctrl_Req ? starve_q + SW'(1) : '0;
        end
      end
      S_SEND: begin
        send_d = 1'b1;
        tcnt_d = '0;
      end
      S_WAIT_BUSY: begin
        if (!i_DAC_Ready) begin
          send_d = 1'b0;
        end else if (timeout_hit) begin
          send_d      = 1'b0;
          err_d       = 1'b1;
          pend_b_d    = 1'b0;
          init_done_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (i_DAC_Ready) begin
          if (pend_b_q) begin
            data_d   = {CHANNEL_B, samp_b_q};
            pend_b_d = 1'b0;
          end else if (!o_Init_Done && !last_init) begin
            idx_d  = idx_q + 2'd1;
            data_d = init_word(idx_q + 2'd1);
          end else if (!o_Init_Done) begin
            init_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Randomized self-checking bench for dac_spi_scheduler with a behavioural
// transmitter model that logs every accepted frame.
module tb_dac_spi_scheduler;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Sample_Req = 1'b0;
  logic [15:0] i_Sample_A = '0;
  logic [15:0] i_Sample_B = '0;
  logic        o_Sample_Ack;
  logic        i_Ctrl_Req = 1'b0;
  logic [23:0] i_Ctrl_Data = '0;
  logic        o_Ctrl_Ack;
  logic [23:0] o_DAC_Data;
  logic        o_DAC_Send;
  logic        i_DAC_Ready = 1'b1;
  logic        o_Init_Done;
  logic        o_Busy;
  logic        o_Error;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int FRAME = 50;
  logic        tx_stuck = 1'b0;
  int          tx_cnt   = 0;
  logic [23:0] sent[$];

  always #5 i_Clock = ~i_Clock;

  dac_spi_scheduler dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset),
    .i_Sample_Req(i_Sample_Req), .i_Sample_A(i_Sample_A), .i_Sample_B(i_Sample_B),
    .o_Sample_Ack(o_Sample_Ack),
    .i_Ctrl_Req(i_Ctrl_Req), .i_Ctrl_Data(i_Ctrl_Data), .o_Ctrl_Ack(o_Ctrl_Ack),
    .o_DAC_Data(o_DAC_Data), .o_DAC_Send(o_DAC_Send), .i_DAC_Ready(i_DAC_Ready),
    .o_Init_Done(o_Init_Done), .o_Busy(o_Busy), .o_Error(o_Error)
  );

  // Transmitter: ready falls the cycle after send is seen, frame lasts FRAME cycles.
  always begin
    @(posedge i_Clock); #1;
    if (i_Reset) begin
      i_DAC_Ready = 1'b1; tx_cnt = 0;
    end else if (tx_stuck) begin
      i_DAC_Ready = 1'b1;
    end else if (i_DAC_Ready && o_DAC_Send) begin
      i_DAC_Ready = 1'b0; tx_cnt = FRAME; sent.push_back(o_DAC_Data);
    end else if (!i_DAC_Ready) begin
      tx_cnt--;
      if (tx_cnt == 0) i_DAC_Ready = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic wait_ack(input bit ctrl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge i_Clock);
      if (ctrl ? o_Ctrl_Ack : o_Sample_Ack) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_not_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge i_Clock);
      if (!o_Busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [23:0] exp[$];
    logic [23:0] got;
    int early;
    bit ok;
    i_Reset = 1'b1;
    i_Sample_A = 16'h1234; i_Sample_B = 16'hABCD;
    repeat (3) @(posedge i_Clock);
    @(negedge i_Clock);
    n_checks++;
    if ({o_Sample_Ack, o_Ctrl_Ack, o_DAC_Data, o_DAC_Send, o_Init_Done, o_Busy, o_Error} !== '0)
      $display("FAIL reset_outputs: got data=%h send=%b busy=%b err=%b, expected all 0",
               o_DAC_Data, o_DAC_Send, o_Busy, o_Error);
    else n_pass++;
    sent.delete();
    i_Sample_Req = 1'b1;
    i_Reset = 1'b0;
    early = 0;
    for (int i = 0; i < 2000 && !o_Init_Done; i++) begin
      @(negedge i_Clock);
      if (o_Sample_Ack || o_Ctrl_Ack) early++;
    end
    n_checks++;
    if (o_Init_Done !== 1'b1) $display("FAIL init_done: got %b, expected 1", o_Init_Done);
    else n_pass++;
    n_checks++;
    if (early != 0) $display("FAIL ack_before_init: got %0d acks, expected 0", early);
    else n_pass++;
    exp = '{24'h3C0000, 24'h300000};
    n_checks++;
    if (sent.size() != 2) $display("FAIL init_count: got %0d words, expected 2", sent.size());
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      got = (i < sent.size()) ? sent[i] : 24'hxxxxxx;
      n_checks++;
      if (got !== exp[i]) $display("FAIL init_word%0d: got %h, expected %h", i, got, exp[i]);
      else n_pass++;
    end
    wait_ack(1'b0, ok);
    i_Sample_Req = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL post_init_ack: got no ack, expected sample ack");
    else n_pass++;
    wait_not_busy(ok);
  endtask

  task automatic test_sample_pair();
    logic [15:0] a, b;
    logic [23:0] got;
    int acks;
    bit ok, ok2;
    for (int k = 0; k < 5; k++) begin
      a = (k == 0) ? 16'h8000 : 16'($urandom);
      b = (k == 0) ? 16'h7FFF : 16'($urandom);
      sent.delete();
      acks = 0;
      i_Sample_A = a; i_Sample_B = b; i_Sample_Req = 1'b1;
      wait_ack(1'b0, ok);
      i_Sample_Req = 1'b0;
      acks += ok ? 1 : 0;
      ok2 = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge i_Clock);
        if (o_Sample_Ack) acks++;
        if (!o_Busy) begin ok2 = 1'b1; break; end
      end
      n_checks++;
      if (!ok2) $display("FAIL pair%0d_busy: got busy=%b, expected 0 after pair", k, o_Busy);
      else n_pass++;
      n_checks++;
      if (acks != 1) $display("FAIL pair%0d_acks: got %0d, expected 1", k, acks);
      else n_pass++;
      got = (sent.size() > 0) ? sent[0] : 24'hxxxxxx;
      n_checks++;
      if (got !== {8'h31, a}) $display("FAIL pair%0d_A: got %h, expected %h", k, got, {8'h31, a});
      else n_pass++;
      got = (sent.size() > 1) ? sent[1] : 24'hxxxxxx;
      n_checks++;
      if (got !== {8'h32, b}) $display("FAIL pair%0d_B: got %h, expected %h", k, got, {8'h32, b});
      else n_pass++;
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] a, b;
    logic [23:0] c, got;
    logic [9:0]  gseq, eseq;
    logic [23:0] exp[$];
    int ng, ncack;
    bit ok;
    a = 16'($urandom); b = 16'($urandom); c = 24'($urandom);
    i_Sample_A = a; i_Sample_B = b; i_Ctrl_Data = c;
    sent.delete();
    ng = 0; ncack = 0; gseq = '0;
    i_Sample_Req = 1'b1; i_Ctrl_Req = 1'b1;
    for (int i = 0; i < 20000 && ng < 10; i++) begin
      @(negedge i_Clock);
      if (o_Ctrl_Ack) begin gseq[ng] = 1'b1; ng++; ncack++; end
      else if (o_Sample_Ack) begin gseq[ng] = 1'b0; ng++; end
    end
    i_Sample_Req = 1'b0; i_Ctrl_Req = 1'b0;
    wait_not_busy(ok);
    // Every fifth grant goes to control when both requesters are held.
    eseq = '0;
    for (int g = 0; g < 10; g++) begin
      eseq[g] = (g % 5 == 4);
      if (eseq[g]) exp.push_back(c);
      else begin exp.push_back({8'h31, a}); exp.push_back({8'h32, b}); end
    end
    n_checks++;
    if (gseq !== eseq) $display("FAIL arb_sequence: got %b, expected %b (bit0 first, 1=ctrl)", gseq, eseq);
    else n_pass++;
    n_checks++;
    if (ncack != 2) $display("FAIL arb_ctrl_acks: got %0d, expected 2", ncack);
    else n_pass++;
    n_checks++;
    if (sent.size() != exp.size()) $display("FAIL arb_words: got %0d, expected %0d", sent.size(), exp.size());
    else n_pass++;
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < sent.size()) ? sent[i] : 24'hxxxxxx;
      n_checks++;
      if (got !== exp[i]) $display("FAIL arb_word%0d: got %h, expected %h", i, got, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ctrl_mid_pair();
    logic [15:0] a, b;
    logic [23:0] c, got;
    bit ok, seen;
    for (int k = 0; k < 2; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      c = (k == 0) ? 24'h0F1234 : 24'($urandom);
      sent.delete();
      i_Sample_A = a; i_Sample_B = b; i_Sample_Req = 1'b1;
      wait_ack(1'b0, ok);
      i_Sample_Req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge i_Clock);
        if (o_DAC_Send && o_DAC_Data[23:16] == 8'h32) begin seen = 1'b1; break; end
      end
      n_checks++;
      if (!seen) $display("FAIL mid%0d_b_start: got no B frame, expected one", k);
      else n_pass++;
      i_Ctrl_Data = c; i_Ctrl_Req = 1'b1;
      wait_ack(1'b1, ok);
      i_Ctrl_Req = 1'b0;
      n_checks++;
      if (!ok || sent.size() != 2 || i_DAC_Ready !== 1'b1)
        $display("FAIL mid%0d_ctrl_wait: got ack=%b words=%0d ready=%b, expected ack after B done (1,2,1)",
                 k, ok, sent.size(), i_DAC_Ready);
      else n_pass++;
      wait_not_busy(ok);
      got = (sent.size() > 2) ? sent[2] : 24'hxxxxxx;
      n_checks++;
      if (got !== c) $display("FAIL mid%0d_ctrl_word: got %h, expected %h", k, got, c);
      else n_pass++;
      got = (sent.size() > 1) ? sent[1] : 24'hxxxxxx;
      n_checks++;
      if (got !== {8'h32, b}) $display("FAIL mid%0d_B: got %h, expected %h", k, got, {8'h32, b});
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    logic [15:0] a, b;
    logic [23:0] got;
    int hi;
    bit ok;
    sent.delete();
    tx_stuck = 1'b1;
    i_Sample_A = 16'($urandom); i_Sample_B = 16'($urandom); i_Sample_Req = 1'b1;
    wait_ack(1'b0, ok);
    i_Sample_Req = 1'b0;
    hi = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge i_Clock);
      if (o_DAC_Send) hi++;
      else if (hi > 0) break;
    end
    n_checks++;
    if (hi != 255) $display("FAIL timeout_len: got %0d send cycles, expected 255", hi);
    else n_pass++;
    repeat (20) @(negedge i_Clock);
    n_checks++;
    if ({o_Error, o_Busy, o_DAC_Send} !== 3'b100)
      $display("FAIL timeout_state: got err/busy/send=%b%b%b, expected 100", o_Error, o_Busy, o_DAC_Send);
    else n_pass++;
    tx_stuck = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    i_Sample_A = a; i_Sample_B = b; i_Sample_Req = 1'b1;
    wait_ack(1'b0, ok);
    i_Sample_Req = 1'b0;
    wait_not_busy(ok);
    got = (sent.size() > 0) ? sent[0] : 24'hxxxxxx;
    n_checks++;
    if (got !== {8'h31, a}) $display("FAIL after_timeout_A: got %h, expected %h", got, {8'h31, a});
    else n_pass++;
    got = (sent.size() > 1) ? sent[1] : 24'hxxxxxx;
    n_checks++;
    if (got !== {8'h32, b}) $display("FAIL after_timeout_B: got %h, expected %h", got, {8'h32, b});
    else n_pass++;
    n_checks++;
    if (o_Error !== 1'b1) $display("FAIL error_sticky: got %b, expected 1", o_Error);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] a, b;
    logic [23:0] exp[$];
    logic [23:0] got;
    int early;
    bit ok, seen;
    i_Sample_A = 16'($urandom); i_Sample_B = 16'($urandom); i_Sample_Req = 1'b1;
    wait_ack(1'b0, ok);
    i_Sample_Req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge i_Clock);
      if (!i_DAC_Ready && o_DAC_Data[23:16] == 8'h32) begin seen = 1'b1; break; end
    end
    repeat (10) @(negedge i_Clock);
    a = 16'($urandom); b = 16'($urandom);
    i_Sample_A = a; i_Sample_B = b; i_Sample_Req = 1'b1;
    i_Reset = 1'b1;
    @(negedge i_Clock);
    n_checks++;
    if (!seen || {o_Sample_Ack, o_Ctrl_Ack, o_DAC_Data, o_DAC_Send, o_Init_Done, o_Busy, o_Error} !== '0)
      $display("FAIL midreset_outputs: got B-frame=%b data=%h send=%b done=%b busy=%b err=%b, expected 1 then all 0",
               seen, o_DAC_Data, o_DAC_Send, o_Init_Done, o_Busy, o_Error);
    else n_pass++;
    i_Reset = 1'b0;
    sent.delete();
    early = 0;
    for (int i = 0; i < 2000 && !o_Init_Done; i++) begin
      @(negedge i_Clock);
      if (o_Sample_Ack || o_Ctrl_Ack) early++;
    end
    n_checks++;
    if (early != 0 || o_Init_Done !== 1'b1)
      $display("FAIL midreset_init: got acks=%0d done=%b, expected 0 and 1", early, o_Init_Done);
    else n_pass++;
    wait_ack(1'b0, ok);
    i_Sample_Req = 1'b0;
    wait_not_busy(ok);
    exp = '{24'h3C0000, 24'h300000, {8'h31, a}, {8'h32, b}};
    for (int i = 0; i < 4; i++) begin
      got = (i < sent.size()) ? sent[i] : 24'hxxxxxx;
      n_checks++;
      if (got !== exp[i]) $display("FAIL midreset_word%0d: got %h, expected %h", i, got, exp[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sample_pair();
    test_arbitration();
    test_ctrl_mid_pair();
    test_timeout();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
